// File: rtl/fifo_nw_1r.sv
`default_nettype none
// ============================================================================
// Module   : fifo_nw_1r
// Purpose  : Multi-write-lane, single-read synchronous FIFO. Up to
//            WRITE_PORTS entries may be pushed per cycle; one entry is
//            popped per cycle. Optional feature macro: FIFO_FWFT_EN
//            (first-word fall-through read port when defined).
// Revision : 1.0  initial release
// ============================================================================
module fifo_nw_1r #(
    parameter int DATA_WIDTH    = 65,
    parameter int ADDRESS_WIDTH = 4,
    parameter int FIFO_DEPTH    = 1 << ADDRESS_WIDTH,
    parameter int WRITE_PORTS   = 2,
    parameter int AFULL_THRESH  = FIFO_DEPTH - WRITE_PORTS
) (
    input  logic                              Clk,
    input  logic                              Clear_in,
    input  logic                              stall,
    input  logic [WRITE_PORTS*DATA_WIDTH-1:0] Data_in,
    input  logic [2:0]                        WriteCnt_in,
    input  logic                              ReadEn_in,
    output logic [DATA_WIDTH-1:0]             Data_out,
    output logic                              Data_valid,
    output logic                              Empty_out,
    output logic                              Full_out,
    output logic                              AlmostFull_out,
    output logic [ADDRESS_WIDTH:0]            Count_out,
    output logic                              Overflow_out
);

    // Occupancy width, and a wider domain so a 3-bit burst length can be
    // compared against free space for any ADDRESS_WIDTH.
    localparam int c_cw = ADDRESS_WIDTH + 1;
    localparam int c_ew = c_cw + 3;
    localparam logic [c_ew-1:0] c_depth = c_ew'(FIFO_DEPTH);
    localparam logic [c_ew-1:0] c_ports = c_ew'(WRITE_PORTS);
    localparam logic [c_ew-1:0] c_afull = c_ew'(AFULL_THRESH);

    logic [DATA_WIDTH-1:0]    r_mem [FIFO_DEPTH];
    logic [ADDRESS_WIDTH-1:0] r_wr_ptr;
    logic [ADDRESS_WIDTH-1:0] r_rd_ptr;
    logic [c_cw-1:0]          r_count;
    logic                     r_ovf;

    logic [c_ew-1:0] w_wcnt;
    logic [c_ew-1:0] w_count_ext;
    logic [c_ew-1:0] w_free;
    logic            w_empty;
    logic            w_wr_req;
    logic            w_wr_fit;
    logic            w_wr_acc;
    logic            w_wr_rej;
    logic            w_pop;
    logic [c_cw-1:0] w_count_next;

    assign w_wcnt      = {{(c_ew-3){1'b0}}, WriteCnt_in};
    assign w_count_ext = {3'b000, r_count};
    // Free space is taken from the registered count only: a same-cycle pop
    // does not make room for a same-cycle write.
    assign w_free      = c_depth - w_count_ext;
    assign w_empty     = (r_count == '0);

    // A burst is all-or-nothing: it must fit both the lanes and the space.
    assign w_wr_req = !stall && !Clear_in && (WriteCnt_in != 3'd0);
    assign w_wr_fit = (w_wcnt <= w_free) && (w_wcnt <= c_ports);
    assign w_wr_acc = w_wr_req && w_wr_fit;
    assign w_wr_rej = w_wr_req && !w_wr_fit;
    assign w_pop    = ReadEn_in && !stall && !Clear_in && !w_empty;

    assign w_count_next = r_count
                        + (w_wr_acc ? w_wcnt[c_cw-1:0] : {c_cw{1'b0}})
                        - {{ADDRESS_WIDTH{1'b0}}, w_pop};

    assign Empty_out      = w_empty;
    assign Full_out       = (w_free < c_ports);
    assign AlmostFull_out = (w_count_ext >= c_afull);
    assign Count_out      = r_count;
    assign Overflow_out   = r_ovf;

    // Pointer, occupancy and overflow-pulse state.
    always_ff @(posedge Clk) begin
        if (Clear_in) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + w_wcnt[ADDRESS_WIDTH-1:0];
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= w_count_next;
            r_ovf   <= w_wr_rej;
        end
    end

    // Storage: lane k of an accepted burst lands at wr_ptr+k (wraps).
    always_ff @(posedge Clk) begin
        for (int k = 0; k < WRITE_PORTS; k++) begin
            if (w_wr_acc && (WriteCnt_in > 3'(k))) begin
                r_mem[r_wr_ptr + ADDRESS_WIDTH'(k)] <= Data_in[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

`ifdef FIFO_FWFT_EN
    // Head entry is shown directly; ReadEn_in acknowledges it.
    assign Data_out   = r_mem[r_rd_ptr];
    assign Data_valid = !w_empty && !stall && !Clear_in;
`else
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_valid;

    // Popped entry is registered; contents are not reset.
    always_ff @(posedge Clk) begin
        if (w_pop) begin
            r_data <= r_mem[r_rd_ptr];
        end
    end

    // Valid strobe follows each accepted pop by one cycle.
    always_ff @(posedge Clk) begin
        if (Clear_in) begin
            r_valid <= 1'b0;
        end else begin
            r_valid <= w_pop;
        end
    end

    assign Data_out   = r_data;
    assign Data_valid = r_valid;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_nw_1r.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_nw_1r
// Purpose  : Self-checking bench for fifo_nw_1r (DATA_WIDTH=8,
//            ADDRESS_WIDTH=3, WRITE_PORTS=2, AFULL_THRESH=6). Honours
//            FIFO_FWFT_EN for the read-side expectations.
// Revision : 1.0  initial release
// ============================================================================
module tb_fifo_nw_1r;

    logic        Clk = 1'b0;
    logic        Clear_in;
    logic        stall;
    logic [15:0] Data_in;
    logic [2:0]  WriteCnt_in;
    logic        ReadEn_in;
    logic [7:0]  Data_out;
    logic        Data_valid;
    logic        Empty_out;
    logic        Full_out;
    logic        AlmostFull_out;
    logic [3:0]  Count_out;
    logic        Overflow_out;

    fifo_nw_1r #(
        .DATA_WIDTH    (8),
        .ADDRESS_WIDTH (3),
        .FIFO_DEPTH    (8),
        .WRITE_PORTS   (2),
        .AFULL_THRESH  (6)
    ) u_dut (
        .Clk            (Clk),
        .Clear_in       (Clear_in),
        .stall          (stall),
        .Data_in        (Data_in),
        .WriteCnt_in    (WriteCnt_in),
        .ReadEn_in      (ReadEn_in),
        .Data_out       (Data_out),
        .Data_valid     (Data_valid),
        .Empty_out      (Empty_out),
        .Full_out       (Full_out),
        .AlmostFull_out (AlmostFull_out),
        .Count_out      (Count_out),
        .Overflow_out   (Overflow_out)
    );

    always #5 Clk = ~Clk;

    int         err_cnt = 0;
    int         chk_cnt = 0;
    int         m_count = 0;
    logic [7:0] sb_fifo [$];   // entries the model believes are stored
    logic [7:0] sb_out  [$];   // popped entries awaiting Data_valid
    bit         m_ovf   = 1'b0;
    bit         m_valid = 1'b0;
    logic [7:0] w_popped;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Drive one cycle of stimulus (entered on a falling edge), update the
    // model, then compare all outputs on the next falling edge.
    task automatic step(input int wcnt, input logic [7:0] l0, input logic [7:0] l1,
                        input bit rd, input bit stl, input bit clr);
        bit pop;
        bit req;
        bit acc;
        Data_in     = {l1, l0};
        WriteCnt_in = 3'(wcnt);
        ReadEn_in   = rd;
        stall       = stl;
        Clear_in    = clr;
        if (clr) begin
            m_count = 0;
            sb_fifo.delete();
            sb_out.delete();
            m_ovf   = 1'b0;
            m_valid = 1'b0;
        end else begin
            pop = rd && !stl && (m_count != 0);
            req = !stl && (wcnt > 0);
            acc = req && (wcnt <= 8 - m_count) && (wcnt <= 2);
            if (pop) begin
                w_popped = sb_fifo.pop_front();
                sb_out.push_back(w_popped);
            end
            if (acc) begin
                sb_fifo.push_back(l0);
                if (wcnt == 2) sb_fifo.push_back(l1);
                m_count = m_count + wcnt;
            end
            if (pop) m_count = m_count - 1;
            m_ovf   = req && !acc;
            m_valid = pop;
        end
        @(posedge Clk);
        #1;
        WriteCnt_in = 3'd0;
        ReadEn_in   = 1'b0;
        stall       = 1'b0;
        Clear_in    = 1'b0;
        @(negedge Clk);
        chk("count",    32'(Count_out),      32'(m_count));
        chk("empty",    32'(Empty_out),      32'(m_count == 0));
        chk("full",     32'(Full_out),       32'((8 - m_count) < 2));
        chk("afull",    32'(AlmostFull_out), 32'(m_count >= 6));
        chk("overflow", 32'(Overflow_out),   32'(m_ovf));
`ifdef FIFO_FWFT_EN
        sb_out.delete();
        chk("valid", 32'(Data_valid), 32'(m_count != 0));
        if (m_count != 0 && Data_valid) chk("head", 32'(Data_out), 32'(sb_fifo[0]));
`else
        chk("valid", 32'(Data_valid), 32'(m_valid));
        if (Data_valid) begin
            if (sb_out.size() == 0) chk("unexpected_pop", 32'(Data_valid), 32'd0);
            else chk("data", 32'(Data_out), 32'(sb_out.pop_front()));
        end
`endif
    endtask

    initial begin
        Clear_in    = 1'b1;
        stall       = 1'b0;
        Data_in     = '0;
        WriteCnt_in = 3'd0;
        ReadEn_in   = 1'b0;
        @(negedge Clk);

        // Reset state
        step(0, 8'h00, 8'h00, 0, 0, 1);

        // Two-lane write then two pops
        step(2, 8'h11, 8'h22, 0, 0, 0);
        step(0, 8'h00, 8'h00, 1, 0, 0);
        step(0, 8'h00, 8'h00, 1, 0, 0);
        step(0, 8'h00, 8'h00, 1, 0, 0);   // pop while empty is ignored

        // Burst wider than the lane count is dropped
        step(3, 8'hA0, 8'hA1, 0, 0, 0);

        // Fill to full, then overflow burst
        for (int i = 0; i < 5; i++) step(2, 8'(8'h30 + 2*i), 8'(8'h31 + 2*i), 0, 0, 0);
        for (int i = 0; i < 8; i++) step(0, 8'h00, 8'h00, 1, 0, 0);

        // Count 7: same-cycle pop does not free space
        step(2, 8'h40, 8'h41, 0, 0, 0);
        step(2, 8'h42, 8'h43, 0, 0, 0);
        step(2, 8'h44, 8'h45, 0, 0, 0);
        step(1, 8'h46, 8'h00, 0, 0, 0);
        step(2, 8'h47, 8'h48, 1, 0, 0);   // rejected, count 7 -> 6
        step(1, 8'h49, 8'h00, 0, 0, 0);   // back to 7
        step(1, 8'h4A, 8'h00, 1, 0, 0);   // stays 7
        step(0, 8'h00, 8'h00, 0, 0, 1);

        // Interleaved traffic across pointer wrap: 12 in, 12 out
        for (int i = 0; i < 6; i++) step(2, 8'($urandom), 8'($urandom), 1, 0, 0);
        for (int i = 0; i < 7; i++) step(0, 8'h00, 8'h00, 1, 0, 0);

        // Stall freezes everything, then clear mid-stream
        step(2, 8'h61, 8'h62, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(2, 8'h70, 8'h71, 1, 1, 0);
        step(0, 8'h00, 8'h00, 1, 0, 0);
        step(2, 8'h63, 8'h64, 1, 0, 1);

        // Single write: fall-through shows it before any read request
        step(1, 8'h5A, 8'h00, 0, 0, 0);
        step(0, 8'h00, 8'h00, 0, 0, 0);
        step(0, 8'h00, 8'h00, 1, 0, 0);
        step(0, 8'h00, 8'h00, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
`default_nettype wire
